note_recorder: RTL and testbench
================================

# note_recorder

Captures a player-entered note sequence from the four note keys and assembles it into the packed level format consumed by the playback and response blocks: first note in the most significant nibble, 4 bits per note. It is the writer side of the level bus, used for custom-level and two-player modes. It sits beside the playback and response blocks inside the game core, driven by the game controller (`start` / `stop`) and the raw key inputs.

## Interface
- `MAX_NOTES`, default 4: capacity in notes; legal range 1..15.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before a key change is accepted; use 500000 on the board.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  single-cycle pulse: clear buffer and begin recording.
- `stop`  in  1  single-cycle pulse: end recording early.
- `note_inputs`  in  4  raw keys, active-high pressed, asynchronous to `clk`.
- `level_data`  out  4*MAX_NOTES  recorded notes, left-justified, unused nibbles 0.
- `level_length`  out  4  number of notes recorded.
- `note_valid`  out  1  one-cycle pulse per accepted note.
- `invalid_press`  out  1  one-cycle pulse when the debounced press is not one-hot.
- `recording`  out  1  high in WAIT_PRESS and WAIT_RELEASE.
- `done`  out  1  high in DONE.
- `note_outputs`  out  4  key echo for the LEDs.

## Operation
- Input path:
  - 2-flop synchroniser on `note_inputs`.
  - Stability counter: `deb` (4 bits) takes the synchronised value after DEBOUNCE_CYCLES consecutive identical samples. The counter restarts on any change.
  - Glitches shorter than DEBOUNCE_CYCLES never reach `deb`.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
  - IDLE: waits for `start`.
  - WAIT_PRESS, when `deb` goes from 0 to nonzero:
    - One-hot `deb`: write it into nibble slot `count` (slot 0 = bits [4*MAX_NOTES-1 : 4*MAX_NOTES-4]), increment `count`, pulse `note_valid`, go to WAIT_RELEASE.
    - Non-one-hot `deb`: pulse `invalid_press`, write nothing, go to WAIT_RELEASE.
  - WAIT_RELEASE: when `deb` == 0, go to DONE if `count` == MAX_NOTES, else WAIT_PRESS.
  - DONE: holds `level_data` and `level_length`. `start` begins a new recording.
- `stop`:
  - In WAIT_PRESS with `count` ≥ 1: go to DONE.
  - With `count` == 0, and in every other state: ignored.
- `start` in any state:
  - clears `level_data` and `count`;
  - goes to WAIT_PRESS;
  - has priority over a simultaneous `stop` or press;
  - a key already held at `start` must be released before it can record.
- `level_length` = `count`. `count` never exceeds MAX_NOTES; there is no wrap-around.

## Timing
- Reset values (asserted asynchronously): state IDLE, `level_data` 0, `level_length` 0, all pulses 0, `recording` 0, `done` 0, `note_outputs` 0, synchroniser, `deb` and stability counter 0.
- Reset mid-recording discards everything.
- Latency: a raw level stable from edge k appears in `deb` at edge k+2+DEBOUNCE_CYCLES. The note write, `count` increment and `note_valid` pulse occur at edge k+3+DEBOUNCE_CYCLES.
- Release uses the same latency; the return to WAIT_PRESS is at edge k+3+DEBOUNCE_CYCLES after release.
- `done` rises on the edge that accepts the final release, or the edge after `stop`.
- All outputs are registered.

## Configuration
- `NOTE_RECORDER_ECHO_EN` defined: `note_outputs` = `deb` while `recording`, else 0.
- Undefined: `note_outputs` is constant 0 and the echo logic is absent.
- Recording behaviour is identical in both builds.

## Test plan
All scenarios use MAX_NOTES=4, DEBOUNCE_CYCLES=4.
- Reset with keys idle, then `start`; press/release 0001, 0010, 0100, 1000, each held 10 cycles. Required: `level_data`=16'h1248, `level_length`=4, four `note_valid` pulses, `done`=1 after the last release. First `note_valid` pulse exactly 7 edges after the first press.
- `start`; press 0010; 3-cycle glitch on 0100; release; `stop`. Required: `level_data`=16'h2000, `level_length`=1, `done`=1, glitch ignored.
- `start`; press 0011. Required: `invalid_press` pulse, `level_length`=0. Then release and press 0001 → `level_data`=16'h1000.
- `stop` with `count`=0, and `stop` while a key is held. Required: both ignored, `recording` stays 1.
- `reset_n` low mid-recording after 2 notes. Required: all outputs 0 immediately. After release and `start`, a new recording starts from slot 0.
- With `NOTE_RECORDER_ECHO_EN` defined, a held key 0100 gives `note_outputs`=0100 while recording and 0000 in DONE. Without the macro, `note_outputs` stays 0000 throughout.

Source files
------------

// File: rtl/note_recorder.sv
// -----------------------------------------------------------------------------
// note_recorder
//
// Captures a player-entered note sequence from the four note keys and packs it
// into the level format used by playback/response: first note in the most
// significant nibble, 4 bits per note, unused nibbles zero.
//
// Parameters
//   MAX_NOTES        capacity in notes (1..15)
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples before a key
//                    change is accepted (use 500000 on the board)
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          pulse: clear buffer and begin recording
//   stop           pulse: end recording early (only with >= 1 note, WAIT_PRESS)
//   note_inputs    raw keys, active-high, asynchronous to clk
//   level_data     recorded notes, left-justified
//   level_length   number of notes recorded
//   note_valid     pulse per accepted note
//   invalid_press  pulse when a debounced press is not one-hot
//   recording      high while waiting for press/release
//   done           high once recording has finished
//   note_outputs   key echo for LEDs
//
// Build option
//   NOTE_RECORDER_ECHO_EN  when defined, note_outputs mirrors the debounced
//                          keys while recording; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module note_recorder #(
  parameter int MAX_NOTES       = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [3:0]             note_inputs,
  output logic [4*MAX_NOTES-1:0] level_data,
  output logic [3:0]             level_length,
  output logic                   note_valid,
  output logic                   invalid_press,
  output logic                   recording,
  output logic                   done,
  output logic [3:0]             note_outputs
);

  localparam int              CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [3:0]      MAX_COUNT = 4'(MAX_NOTES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    sync1, sync2;
  logic [3:0]    deb, deb_prev;
  logic [CW-1:0] stab_cnt;
  logic [3:0]    count;

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce.
  // sync1 holds the next sample of sync2, so sync1 != sync2 flags a change
  // arriving and restarts the stability count. Once sync2 has differed from
  // deb for DEBOUNCE_CYCLES consecutive samples, deb takes it; the update
  // itself is checked first so a change arriving on that very edge does not
  // throw away an already-qualified value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      stab_cnt <= '0;
    end else begin
      sync1    <= note_inputs;
      sync2    <= sync1;
      deb_prev <= deb;
      if (sync2 == deb) begin
        stab_cnt <= '0;
      end else if (stab_cnt == CNT_MAX) begin
        deb      <= sync2;
        stab_cnt <= '0;
      end else if (sync1 != sync2) begin
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  // A press is only the 0 -> nonzero transition of deb, so a key already
  // held when recording starts must be released before it counts.
  logic press_edge;
  logic deb_onehot;
  assign press_edge = (deb_prev == 4'd0) && (deb != 4'd0);
  assign deb_onehot = (deb != 4'd0) && ((deb & (deb - 4'd1)) == 4'd0);

  // ---------------------------------------------------------------------------
  // Recording FSM. Status outputs are registered alongside the state so that
  // done/recording change on the same edge as the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      level_data    <= '0;
      count         <= '0;
      note_valid    <= 1'b0;
      invalid_press <= 1'b0;
      recording     <= 1'b0;
      done          <= 1'b0;
    end else begin
      note_valid    <= 1'b0;
      invalid_press <= 1'b0;
      if (start) begin
        // start wins over any simultaneous stop or press
        state      <= WAIT_PRESS;
        level_data <= '0;
        count      <= '0;
        recording  <= 1'b1;
        done       <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          WAIT_PRESS: begin
            if (stop && count != 4'd0) begin
              state     <= DONE;
              recording <= 1'b0;
              done      <= 1'b1;
            end else if (press_edge) begin
              state <= WAIT_RELEASE;
              if (deb_onehot) begin
                if (count < MAX_COUNT) begin
                  for (int i = 0; i < MAX_NOTES; i++) begin
                    if (count == 4'(i))
                      level_data[4*(MAX_NOTES-1-i) +: 4] <= deb;
                  end
                  count      <= count + 4'd1;
                  note_valid <= 1'b1;
                end
              end else begin
                invalid_press <= 1'b1;
              end
            end
          end
          WAIT_RELEASE: begin
            if (deb == 4'd0) begin
              if (count == MAX_COUNT) begin
                state     <= DONE;
                recording <= 1'b0;
                done      <= 1'b1;
              end else begin
                state <= WAIT_PRESS;
              end
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign level_length = count;

`ifdef NOTE_RECORDER_ECHO_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) note_outputs <= '0;
    else          note_outputs <= recording ? deb : 4'd0;
  end
`else
  assign note_outputs = 4'd0;
`endif

endmodule

// File: tb/tb_note_recorder.sv
module tb_note_recorder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop;
  logic [3:0]  note_inputs;
  logic [15:0] level_data;
  logic [3:0]  level_length;
  logic        note_valid, invalid_press, recording, done;
  logic [3:0]  note_outputs;

  note_recorder #(.MAX_NOTES(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .note_inputs  (note_inputs),
    .level_data   (level_data),
    .level_length (level_length),
    .note_valid   (note_valid),
    .invalid_press(invalid_press),
    .recording    (recording),
    .done         (done),
    .note_outputs (note_outputs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        inv;
    logic [15:0] data;
    logic [3:0]  len;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef NOTE_RECORDER_ECHO_EN
  localparam logic [3:0] ECHO_HELD = 4'b0100;
`else
  localparam logic [3:0] ECHO_HELD = 4'b0000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  task automatic expect_ev(input logic inv, input logic [15:0] d, input logic [3:0] l);
    exp_t e;
    e.inv = inv; e.data = d; e.len = l;
    q.push_back(e);
  endtask

  // press a key pattern for 10 cycles, then release for 10 cycles
  task automatic press_release(input logic [3:0] k);
    note_inputs = k;    tick(10);
    note_inputs = 4'd0; tick(10);
  endtask

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_n && (note_valid || invalid_press)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, invalid_press, note_valid}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {31'd0, invalid_press}, {31'd0, e.inv});
        chk("pulse_data", {16'd0, level_data}, {16'd0, e.data});
        chk("pulse_len",  {28'd0, level_length}, {28'd0, e.len});
      end
    end
  end

  int lat;

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; note_inputs = 4'd0;
    #1;
    chk("rst_data", {16'd0, level_data}, 32'd0);
    chk("rst_len",  {28'd0, level_length}, 32'd0);
    chk("rst_flags", {28'd0, note_valid, invalid_press, recording, done}, 32'd0);
    chk("rst_echo", {28'd0, note_outputs}, 32'd0);
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("idle_recording", {31'd0, recording}, 32'd0);

    // ---- Scenario 1: four notes, full buffer ----
    pulse_start();
    chk("s1_recording", {31'd0, recording}, 32'd1);
    expect_ev(1'b0, 16'h1000, 4'd1);
    note_inputs = 4'b0001;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (note_valid) begin lat = i; break; end
    end
    chk("s1_first_latency", 32'(lat), 32'd7);
    tick(3);
    note_inputs = 4'd0; tick(10);
    expect_ev(1'b0, 16'h1200, 4'd2); press_release(4'b0010);
    expect_ev(1'b0, 16'h1240, 4'd3); press_release(4'b0100);
    expect_ev(1'b0, 16'h1248, 4'd4); press_release(4'b1000);
    chk("s1_data", {16'd0, level_data}, 32'h1248);
    chk("s1_len",  {28'd0, level_length}, 32'd4);
    chk("s1_done", {30'd0, done, recording}, 32'b10);

    // ---- Scenario 2: glitch ignored, stop after one note ----
    pulse_start();
    chk("s2_cleared", {16'd0, level_data}, 32'd0);
    chk("s2_done_low", {31'd0, done}, 32'd0);
    expect_ev(1'b0, 16'h2000, 4'd1);
    press_release(4'b0010);
    note_inputs = 4'b0100; tick(3);
    note_inputs = 4'd0;    tick(10);
    pulse_stop();
    chk("s2_done", {31'd0, done}, 32'd1);
    chk("s2_data", {16'd0, level_data}, 32'h2000);
    chk("s2_len",  {28'd0, level_length}, 32'd1);

    // ---- Scenario 3: invalid press then valid ----
    pulse_start();
    expect_ev(1'b1, 16'h0000, 4'd0);
    press_release(4'b0011);
    chk("s3_len_after_invalid", {28'd0, level_length}, 32'd0);
    expect_ev(1'b0, 16'h1000, 4'd1);
    press_release(4'b0001);
    chk("s3_data", {16'd0, level_data}, 32'h1000);
    chk("s3_recording", {31'd0, recording}, 32'd1);

    // ---- Scenario 4: stop ignored with count 0 and with key held ----
    pulse_start();
    pulse_stop();
    tick(1);
    chk("s4_stop_empty", {30'd0, recording, done}, 32'b10);
    expect_ev(1'b0, 16'h1000, 4'd1);
    note_inputs = 4'b0001; tick(10);
    pulse_stop();
    tick(1);
    chk("s4_stop_held", {30'd0, recording, done}, 32'b10);
    note_inputs = 4'd0; tick(10);
    chk("s4_after_release", {30'd0, recording, done}, 32'b10);

    // ---- Scenario 5: reset mid-recording ----
    pulse_start();
    expect_ev(1'b0, 16'h1000, 4'd1); press_release(4'b0001);
    expect_ev(1'b0, 16'h1200, 4'd2); press_release(4'b0010);
    note_inputs = 4'b0100; tick(3);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_rst_data", {16'd0, level_data}, 32'd0);
    chk("s5_rst_len",  {28'd0, level_length}, 32'd0);
    chk("s5_rst_flags", {28'd0, note_valid, invalid_press, recording, done}, 32'd0);
    chk("s5_rst_echo", {28'd0, note_outputs}, 32'd0);
    tick(2);
    note_inputs = 4'd0;
    reset_n = 1'b1;
    tick(2);
    pulse_start();
    expect_ev(1'b0, 16'h4000, 4'd1); press_release(4'b0100);
    chk("s5_restart_data", {16'd0, level_data}, 32'h4000);

    // ---- Scenario 6: LED echo ----
    pulse_start();
    expect_ev(1'b0, 16'h4000, 4'd1);
    note_inputs = 4'b0100; tick(10);
    chk("s6_echo_recording", {28'd0, note_outputs}, {28'd0, ECHO_HELD});
    note_inputs = 4'd0; tick(10);
    pulse_stop();
    note_inputs = 4'b0100; tick(10);
    chk("s6_done", {31'd0, done}, 32'd1);
    chk("s6_echo_done", {28'd0, note_outputs}, 32'd0);
    chk("s6_data_held", {16'd0, level_data}, 32'h4000);
    note_inputs = 4'd0; tick(10);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
